// File: rtl/lynx_pkt_pkg.sv
// Lynx trace packet layout helpers and generator state encoding.
package lynx_pkt_pkg;

   localparam int unsigned MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      GAP_WAIT = 2'd0,
      SEND     = 2'd1,
      FINISHED = 2'd2
   } tpg_state_t;

   // Width of the running data counter field.
   function automatic int unsigned data_width(input int unsigned width, input int unsigned a);
      return width - 2 * a - 8;
   endfunction

   // MSB position of the 8-bit generator ID field.
   function automatic int unsigned id_pos(input int unsigned width, input int unsigned a);
      return data_width(width, a) + 7;
   endfunction

   // MSB position of the destination field.
   function automatic int unsigned dst_pos(input int unsigned width, input int unsigned a);
      return width - 1 - a;
   endfunction

   // MSB position of the source field.
   function automatic int unsigned src_pos(input int unsigned width, input int unsigned a);
      return dst_pos(width, a) + a;
   endfunction

   // Assemble {src, dst, id, data} right-aligned in a MAX_WIDTH word.
   function automatic logic [MAX_WIDTH-1:0] pack_pkt(
      input int unsigned          width,
      input int unsigned          a,
      input logic [MAX_WIDTH-1:0] src,
      input logic [MAX_WIDTH-1:0] dst,
      input logic [7:0]           id,
      input logic [MAX_WIDTH-1:0] data
   );
      logic [MAX_WIDTH-1:0] amask;
      logic [MAX_WIDTH-1:0] dmask;
      int unsigned          dw;
      dw    = data_width(width, a);
      amask = (MAX_WIDTH'(1) << a) - MAX_WIDTH'(1);
      dmask = (MAX_WIDTH'(1) << dw) - MAX_WIDTH'(1);
      return ((src & amask) << (src_pos(width, a) + 1 - a))
           | ((dst & amask) << (dst_pos(width, a) + 1 - a))
           | (MAX_WIDTH'(id) << (id_pos(width, a) - 7))
           | (data & dmask);
   endfunction

endpackage

// File: rtl/tpg_dest_sel.sv
// Round-robin destination pointer over 0..N-1 that never selects its own node.
module tpg_dest_sel #(
   parameter int unsigned N    = 16,
   parameter int unsigned A    = 4,
   parameter int unsigned NODE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         adv,
   output logic [A-1:0] ptr,
   output logic [A-1:0] ptr_next_c
);

   localparam logic [A-1:0] LAST  = A'(N - 1);
   localparam logic [A-1:0] SELF  = A'(NODE);
   localparam logic [A-1:0] FIRST = (NODE == 0) ? A'(1) : A'(0);

   logic [A-1:0] step_c;

   // Next node with wrap, stepping once more if that lands on our own node.
   always_comb begin
      step_c     = (ptr == LAST) ? '0 : ptr + A'(1);
      ptr_next_c = step_c;
      if (step_c == SELF) begin
         ptr_next_c = (step_c == LAST) ? '0 : step_c + A'(1);
      end
   end

   // Pointer register, advanced once per accepted packet.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= FIRST;
      end else if (adv) begin
         ptr <= ptr_next_c;
      end
   end

endmodule

// File: rtl/tpg.sv
// Traffic pattern generator: streams Lynx trace packets over valid/ready.
module tpg
   import lynx_pkt_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned N            = 16,
   parameter int unsigned N_ADDR_WIDTH = $clog2(N),
   parameter logic [7:0]  ID           = 8'd0,
   parameter int unsigned NODE         = 0,
   parameter int unsigned DEST         = 15,
   parameter int unsigned DEST_MODE    = 0,
   parameter int unsigned NUM_PACKETS  = 1002,
   parameter int unsigned GAP          = 0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   input  logic             ready_in
);

   localparam int unsigned A    = N_ADDR_WIDTH;
   localparam int          DW_S = int'(WIDTH) - 2 * int'(A) - 8;
   localparam int unsigned DW   = (DW_S < 1) ? 1 : DW_S;
   localparam int unsigned SW_R = $clog2(NUM_PACKETS + 1);
   localparam int unsigned SW   = (SW_R < 1) ? 1 : SW_R;
   localparam int unsigned GW_R = $clog2(GAP + 1);
   localparam int unsigned GW   = (GW_R < 1) ? 1 : GW_R;

   // Parameter sanity checks at elaboration.
   if (DW_S < 1) begin : g_bad_dw
      $error("tpg: WIDTH too small for src/dst/id fields");
   end
   if (WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("tpg: WIDTH exceeds packing helper width");
   end
   if (DW < 64 && 64'(NUM_PACKETS) > (64'd1 << DW)) begin : g_bad_num
      $error("tpg: NUM_PACKETS exceeds data counter range");
   end
   if (DEST >= N) begin : g_bad_dest
      $error("tpg: DEST out of range");
   end
   if (DEST_MODE != 0 && N < 2) begin : g_bad_rr
      $error("tpg: round-robin needs at least two nodes");
   end

   tpg_state_t state, state_nxt;

   logic [DW-1:0]    cnt, cnt_d;
   logic [GW-1:0]    gap_cnt, gap_d;
   logic [SW-1:0]    sent, sent_d;
   logic [WIDTH-1:0] data_d;
   logic             valid_d;
   logic             done_d;

   logic             hs_c;
   logic             sent_done_c;
   logic             last_c;
   logic [A-1:0]     ptr;
   logic [A-1:0]     ptr_next_c;
   logic [A-1:0]     cur_dst_c;
   logic [A-1:0]     nxt_dst_c;
   logic [DW-1:0]    cnt_inc_c;

   // Build one packet from this node to dst carrying the given counter.
   function automatic logic [WIDTH-1:0] pkt(input logic [A-1:0] dst, input logic [DW-1:0] data);
      return WIDTH'(pack_pkt(WIDTH, A, MAX_WIDTH'(NODE), MAX_WIDTH'(dst), ID, MAX_WIDTH'(data)));
   endfunction

   assign hs_c        = valid_out & ready_in;
   assign sent_done_c = (32'(sent) >= NUM_PACKETS);
   assign last_c      = (32'(sent) + 32'd1 == NUM_PACKETS);
   assign cnt_inc_c   = cnt + DW'(1);
   assign cur_dst_c   = (DEST_MODE != 0) ? ptr        : A'(DEST);
   assign nxt_dst_c   = (DEST_MODE != 0) ? ptr_next_c : A'(DEST);

   tpg_dest_sel #(
      .N    (N),
      .A    (A),
      .NODE (NODE)
   ) u_dest_sel (
      .clk        (clk),
      .rst        (rst),
      .adv        (hs_c),
      .ptr        (ptr),
      .ptr_next_c (ptr_next_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= GAP_WAIT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         GAP_WAIT: begin
            if (gap_cnt == '0) begin
               state_nxt = sent_done_c ? FINISHED : SEND;
            end
         end
         SEND: begin
            if (hs_c) begin
               if (last_c) begin
                  state_nxt = FINISHED;
               end else if (GAP != 0) begin
                  state_nxt = GAP_WAIT;
               end
            end
         end
         FINISHED: state_nxt = FINISHED;
         default:  state_nxt = GAP_WAIT;
      endcase
   end

   // Next values of the registered outputs and counters.
   always_comb begin
      valid_d = valid_out;
      data_d  = data_out;
      done_d  = done;
      cnt_d   = cnt;
      gap_d   = gap_cnt;
      sent_d  = sent;
      unique case (state)
         GAP_WAIT: begin
            valid_d = 1'b0;
            if (gap_cnt != '0) begin
               gap_d = gap_cnt - GW'(1);
            end else if (sent_done_c) begin
               done_d = 1'b1;
            end else begin
               valid_d = 1'b1;
               data_d  = pkt(cur_dst_c, cnt);
            end
         end
         SEND: begin
            if (hs_c) begin
               cnt_d  = cnt_inc_c;
               sent_d = sent + SW'(1);
               if (last_c) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else if (GAP == 0) begin
                  data_d = pkt(nxt_dst_c, cnt_inc_c);
               end else begin
                  valid_d = 1'b0;
                  gap_d   = GW'(GAP - 1);
               end
            end
         end
         FINISHED: begin
            valid_d = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            valid_d = 1'b0;
         end
      endcase
   end

   // Output and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         done      <= 1'b0;
         cnt       <= '0;
         gap_cnt   <= '0;
         sent      <= '0;
      end else begin
         valid_out <= valid_d;
         data_out  <= data_d;
         done      <= done_d;
         cnt       <= cnt_d;
         gap_cnt   <= gap_d;
         sent      <= sent_d;
      end
   end

endmodule
